// File: rtl/axi_arb_pkg.sv
// ============================================================================
//  Module   : axi_arb_pkg
//  Brief    : Shared AXI widths and arbiter state encoding for the read-port
//             arbiter and its round-robin selector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_arb_pkg;

    localparam int AXI_AW = 40;   // address width
    localparam int AXI_DW = 64;   // data width
    localparam int AXI_LW = 8;    // burst length width

    // Idle: waiting for any request; Addr: AR issued; Data: R beats flowing
    typedef enum logic [1:0] {
        Idle = 2'd0,
        Addr = 2'd1,
        Data = 2'd2
    } arb_st_t;

endpackage

`default_nettype wire

// File: rtl/axi_rd_arb_rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin selector. Returns the first set
//             request found searching last+1, last+2, ... modulo NR.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NR = 4,
    parameter int IW = $clog2(NR)
) (
    input  logic [NR-1:0] req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] w_pos;

    // Scan from the farthest position back to the nearest so the requester
    // closest after 'last' overwrites everything else and wins.
    always_comb begin
        any   = |req;
        idx   = '0;
        w_pos = '0;
        for (int k = NR; k >= 1; k--) begin
            w_pos = IW'((int'(last) + k) % NR);
            if (req[w_pos]) begin
                idx = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_rd_arb.sv
// ============================================================================
//  Module   : axi_rd_arb
//  Brief    : Round-robin arbiter sharing one AXI4 read channel (AR + R)
//             among NR read-cache requesters. One burst outstanding; the
//             grant is held from AR issue until the rlast beat is accepted.
//  Options  : AXI_RD_ARB_MON_EN - adds the arbmon[31:0] status port with
//             beat and burst counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_arb
    import axi_arb_pkg::*;
#(
    parameter int NR = 4,
    parameter int IW = $clog2(NR)
) (
    input  logic                 aclk,
    input  logic                 arst_n,
    input  logic [NR*AXI_AW-1:0] s_araddr,
    input  logic [NR*AXI_LW-1:0] s_arlen,
    input  logic [NR-1:0]        s_arvalid,
    output logic [NR-1:0]        s_arready,
    output logic [AXI_DW-1:0]    s_rd_data,
    output logic [NR-1:0]        s_rvalid,
    output logic [NR-1:0]        s_rlast,
    input  logic [NR-1:0]        s_rready,
    output logic [AXI_AW-1:0]    m_araddr,
    output logic [AXI_LW-1:0]    m_arlen,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    input  logic [AXI_DW-1:0]    m_rd_data,
    input  logic                 m_rvalid,
    input  logic                 m_rlast,
    output logic                 m_rready,
`ifdef AXI_RD_ARB_MON_EN
    output logic [31:0]          arbmon,
`endif
    output logic                 busy
);

    arb_st_t                    r_state;
    arb_st_t                    w_state_nxt;
    logic [IW-1:0]              r_gnt;
    logic [IW-1:0]              r_last;
    logic [AXI_AW+AXI_LW-1:0]   r_ar_q;

    logic                       w_any;
    logic [IW-1:0]              w_idx;
    logic                       w_pick;
    logic                       w_r_hs;
    logic                       w_last_hs;

    logic [AXI_AW-1:0]          w_req_addr [NR];
    logic [AXI_LW-1:0]          w_req_len  [NR];

    // Unpack the per-requester address/length slices into arrays
    for (genvar gi = 0; gi < NR; gi++) begin : g_req_slice
        assign w_req_addr[gi] = s_araddr[gi*AXI_AW +: AXI_AW];
        assign w_req_len[gi]  = s_arlen[gi*AXI_LW +: AXI_LW];
    end

    rr_pick #(
        .NR (NR),
        .IW (IW)
    ) u_rr_pick (
        .req  (s_arvalid),
        .last (r_last),
        .any  (w_any),
        .idx  (w_idx)
    );

    assign w_pick    = (r_state == Idle) && w_any;
    assign w_r_hs    = (r_state == Data) && m_rvalid && m_rready;
    assign w_last_hs = w_r_hs && m_rlast;

    // Address is issued from the registered copy so it stays stable even if
    // the requester drops arvalid while the AR handshake is pending.
    assign m_araddr  = r_ar_q[AXI_AW+AXI_LW-1:AXI_LW];
    assign m_arlen   = r_ar_q[AXI_LW-1:0];
    assign s_rd_data = m_rd_data;
    assign busy      = (r_state != Idle);

    // Next-state logic and per-grant routing of AR/R handshake signals
    always_comb begin
        w_state_nxt = r_state;
        s_arready   = '0;
        s_rvalid    = '0;
        s_rlast     = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        case (r_state)
            Idle: begin
                if (w_any) begin
                    w_state_nxt = Addr;
                end
            end
            Addr: begin
                m_arvalid        = 1'b1;
                s_arready[r_gnt] = m_arready;
                if (m_arready) begin
                    w_state_nxt = Data;
                end
            end
            Data: begin
                m_rready        = s_rready[r_gnt];
                s_rvalid[r_gnt] = m_rvalid;
                s_rlast[r_gnt]  = m_rlast;
                if (m_rvalid && s_rready[r_gnt] && m_rlast) begin
                    w_state_nxt = Idle;
                end
            end
            default: begin
                w_state_nxt = Idle;
            end
        endcase
    end

    // State, grant, round-robin pointer and latched AR request
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= Idle;
            r_gnt   <= '0;
            r_last  <= IW'(NR - 1);
            r_ar_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pick) begin
                r_gnt  <= w_idx;
                r_ar_q <= {w_req_addr[w_idx], w_req_len[w_idx]};
            end
            if (w_last_hs) begin
                r_last <= r_gnt;
            end
        end
    end

`ifdef AXI_RD_ARB_MON_EN
    logic [7:0]  r_beat_cnt;
    logic [15:0] r_burst_cnt;

    // Beat counter restarts with each new burst; burst counter wraps freely
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_beat_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_pick) begin
                r_beat_cnt <= '0;
            end else if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_last_hs) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
        end
    end

    assign arbmon = {r_state, 2'b00, 4'(r_gnt), r_beat_cnt, r_burst_cnt};
`endif

endmodule

`default_nettype wire
